// File: rtl/mbi5153_pkg.sv
// mbi5153_pkg
//   Shared constants and types for the MBI5153 line buffer.
//   - default chain geometry and the derived line length / address width
//   - read-FSM state encoding
//   - lane slice width (one RGB888 word per lane)

package mbi5153_pkg;

  localparam int NUM_IC_CHAIN_DEF    = 4;
  localparam int NUM_CH_IC_DEF       = 16;
  localparam int NUMBER_OF_LANES_DEF = 3;

  // One lane is {R,G,B}, 8 bits each.
  localparam int LANE_W    = 24;
  localparam int MAX_LANES = 3;

  function automatic int line_len(input int ics, input int chs);
    return ics * chs;
  endfunction

  // Never let the address collapse to zero bits for a degenerate 1-word line.
  function automatic int addr_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  localparam int LINE_LEN_DEF   = line_len(NUM_IC_CHAIN_DEF, NUM_CH_IC_DEF);
  localparam int ADDR_WIDTH_DEF = addr_width(LINE_LEN_DEF);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACT  = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } rd_state_t;

endpackage

// File: rtl/mbi5153_line_ram.sv
// mbi5153_line_ram
//   Simple dual-port RAM holding both line banks. One write port, one
//   synchronous read port with a single register stage. The array itself is
//   not reset; only the read register is, so the outputs come up at zero.
//
// Ports
//   CLK      in   clock
//   RESET    in   async active-high, clears the read register only
//   wr_en    in   write strobe
//   wr_addr  in   write address {bank, word}
//   wr_data  in   write word
//   rd_addr  in   read address {bank, word}
//   rd_data  out  registered read word, valid one CLK after rd_addr

module mbi5153_line_ram #(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 7
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write on an address collision; the serializer never reads
  // the bank currently being filled, so the collision case is not relied on.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mbi5153_line_buf.sv
// mbi5153_line_buf
//   Ping-pong line buffer in front of the MBI5153 serializer. One bank fills
//   from the frame-memory reader while the other is shifted out; the read
//   FSM requests a transfer whenever the read bank is full and frees it on
//   the serializer's TX_DONE.
//
// Ports
//   CLK            in   system / serializer clock
//   RESET          in   async active-high
//   WR_VALID       in   write word valid
//   WR_READY       out  buffer can take a word
//   WR_DATA        in   lane k at [24k+23:24k], {R,G,B}
//   WR_LAST        in   last word of the line
//   DRV_READY      in   serializer READY
//   DRV_ACTIVE     in   serializer ACTIVE
//   DRV_TX_DONE    in   serializer TX_DONE strobe
//   DRV_REQUEST    out  one-cycle request to send the read bank
//   RD_ADDR        in   serializer word address
//   DATA0..DATA2   out  lane data, one CLK after RD_ADDR; unused lanes 0
//   LINE_SENT      out  one-cycle pulse when a bank is released
//   LINES_PENDING  out  number of full banks
//   ERR_FRAMING    out  sticky: line length and WR_LAST disagreed
//
// Read FSM
//   state      | meaning
//   IDLE       | read bank not yet handed out; request once it is full
//   WAIT_ACT   | request issued, waiting for the serializer to go active
//   WAIT_DONE  | serializer shifting the line out
//   RELEASE    | free the read bank, flip to the other bank

module mbi5153_line_buf
  import mbi5153_pkg::*;
#(
  parameter int NUM_IC_CHAIN    = NUM_IC_CHAIN_DEF,
  parameter int NUM_CH_IC       = NUM_CH_IC_DEF,
  parameter int NUMBER_OF_LANES = NUMBER_OF_LANES_DEF,
  parameter int LINE_LEN        = line_len(NUM_IC_CHAIN, NUM_CH_IC),
  parameter int ADDR_WIDTH      = addr_width(LINE_LEN)
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              WR_VALID,
  output logic                              WR_READY,
  input  logic [LANE_W*NUMBER_OF_LANES-1:0] WR_DATA,
  input  logic                              WR_LAST,
  input  logic                              DRV_READY,
  input  logic                              DRV_ACTIVE,
  input  logic                              DRV_TX_DONE,
  output logic                              DRV_REQUEST,
  input  logic [ADDR_WIDTH-1:0]             RD_ADDR,
  output logic [LANE_W-1:0]                 DATA0,
  output logic [LANE_W-1:0]                 DATA1,
  output logic [LANE_W-1:0]                 DATA2,
  output logic                              LINE_SENT,
  output logic [1:0]                        LINES_PENDING,
  output logic                              ERR_FRAMING
);

  localparam int DATA_W = LANE_W * NUMBER_OF_LANES;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LINE_LEN - 1);

  logic [1:0]            full;
  logic                  wb;
  logic                  rb;
  logic [ADDR_WIDTH-1:0] wr_cnt;

  rd_state_t state;
  rd_state_t state_nxt;

  logic       wr_accept;
  logic       wr_at_end;
  logic       wr_close;
  logic       rel;
  logic [1:0] set_mask;
  logic [1:0] clr_mask;

  logic [DATA_W-1:0]           rd_data;
  logic [MAX_LANES*LANE_W-1:0] lanes_all;

  // ---------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------
  assign WR_READY  = ~full[wb] & ~RESET;
  assign wr_accept = WR_VALID & WR_READY;
  assign wr_at_end = (wr_cnt == LAST_IDX);
  // A line closes on WR_LAST or on running out of addresses, whichever
  // comes first; the mismatch case is flagged but the line is still kept.
  assign wr_close  = wr_accept & (WR_LAST | wr_at_end);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wb          <= 1'b0;
      wr_cnt      <= '0;
      ERR_FRAMING <= 1'b0;
    end else if (wr_accept) begin
      if (WR_LAST != wr_at_end) begin
        ERR_FRAMING <= 1'b1;
      end
      if (wr_close) begin
        wb     <= ~wb;
        wr_cnt <= '0;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Bank occupancy. Close only hits the (empty) write bank and release only
  // hits the (full) read bank, so both can land in the same cycle.
  // ---------------------------------------------------------------------
  assign rel      = (state == ST_RELEASE);
  assign set_mask = {wr_close & wb, wr_close & ~wb};
  assign clr_mask = {rel & rb, rel & ~rb};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      full <= 2'b00;
      rb   <= 1'b0;
    end else begin
      full <= (full & ~clr_mask) | set_mask;
      if (rel) begin
        rb <= ~rb;
      end
    end
  end

  assign LINES_PENDING = {1'b0, full[0]} + {1'b0, full[1]};

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    DRV_REQUEST = 1'b0;
    LINE_SENT   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full[rb] & DRV_READY) begin
          DRV_REQUEST = 1'b1;
          state_nxt   = ST_WAIT_ACT;
        end
      end
      ST_WAIT_ACT: begin
        // A very short transfer can finish before ACTIVE is ever seen.
        if (DRV_TX_DONE) begin
          state_nxt = ST_RELEASE;
        end else if (DRV_ACTIVE) begin
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (DRV_TX_DONE) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        LINE_SENT = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Storage and read path
  // ---------------------------------------------------------------------
  mbi5153_line_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_WIDTH + 1)
  ) u_ram (
    .CLK     (CLK),
    .RESET   (RESET),
    .wr_en   (wr_accept),
    .wr_addr ({wb, wr_cnt}),
    .wr_data (WR_DATA),
    .rd_addr ({rb, RD_ADDR}),
    .rd_data (rd_data)
  );

  for (genvar k = 0; k < MAX_LANES; k++) begin : g_lane
    if (k < NUMBER_OF_LANES) begin : g_used
      assign lanes_all[k*LANE_W +: LANE_W] = rd_data[k*LANE_W +: LANE_W];
    end else begin : g_unused
      assign lanes_all[k*LANE_W +: LANE_W] = '0;
    end
  end

  assign DATA0 = lanes_all[0*LANE_W +: LANE_W];
  assign DATA1 = lanes_all[1*LANE_W +: LANE_W];
  assign DATA2 = lanes_all[2*LANE_W +: LANE_W];

endmodule

// File: tb/tb_mbi5153_line_buf.sv
// Bench for mbi5153_line_buf: directed scenarios followed by a random run,
// all cycles compared against a bank-level behavioural model.

module tb_mbi5153_line_buf;

  localparam int LANES    = 3;
  localparam int LINE_LEN = 64;
  localparam int DW       = 24 * LANES;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          WR_VALID = 1'b0;
  logic          WR_READY;
  logic [DW-1:0] WR_DATA = '0;
  logic          WR_LAST = 1'b0;
  logic          DRV_READY = 1'b0;
  logic          DRV_ACTIVE = 1'b0;
  logic          DRV_TX_DONE = 1'b0;
  logic          DRV_REQUEST;
  logic [5:0]    RD_ADDR = '0;
  logic [23:0]   DATA0, DATA1, DATA2;
  logic          LINE_SENT;
  logic [1:0]    LINES_PENDING;
  logic          ERR_FRAMING;

  mbi5153_line_buf dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .WR_VALID      (WR_VALID),
    .WR_READY      (WR_READY),
    .WR_DATA       (WR_DATA),
    .WR_LAST       (WR_LAST),
    .DRV_READY     (DRV_READY),
    .DRV_ACTIVE    (DRV_ACTIVE),
    .DRV_TX_DONE   (DRV_TX_DONE),
    .DRV_REQUEST   (DRV_REQUEST),
    .RD_ADDR       (RD_ADDR),
    .DATA0         (DATA0),
    .DATA1         (DATA1),
    .DATA2         (DATA2),
    .LINE_SENT     (LINE_SENT),
    .LINES_PENDING (LINES_PENDING),
    .ERR_FRAMING   (ERR_FRAMING)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int req_seen  = 0;
  int sent_seen = 0;
  bit last_acc  = 1'b0;

  // Model: which banks hold a complete line, where the writer and reader
  // are, and the line handed to the serializer. m_phase: 0 = no line out,
  // 1 = line handed out and not yet finished, 2 = bank being freed.
  bit            m_full [2];
  bit            m_wb, m_rb, m_err;
  int            m_cnt, m_phase;
  logic [DW-1:0] m_mem [2*LINE_LEN];
  bit            m_ok  [2*LINE_LEN];
  logic [DW-1:0] m_dout;
  bit            m_dout_ok;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    m_wb = 1'b0; m_rb = 1'b0; m_err = 1'b0;
    m_cnt = 0; m_phase = 0;
    foreach (m_ok[i]) m_ok[i] = 1'b0;
    m_dout = '0; m_dout_ok = 1'b1;
  endfunction

  function automatic logic [DW-1:0] pat(input int i, input logic [7:0] s);
    logic [7:0]  b;
    logic [23:0] w;
    b = i[7:0];
    w = {b ^ s, (8'h40 + b) ^ s, (8'h80 + b) ^ s};
    return {LANES{w}};
  endfunction

  // One clock: compare at the falling edge, advance the model, return 1 ns
  // after the rising edge so callers can drive the next inputs.
  task automatic step();
    bit            exp_ready, exp_req, acc, at_end, close;
    int            waddr, raddr;
    logic [DW-1:0] nd;
    bit            nd_ok;
    @(negedge CLK);
    if (RESET) model_reset();
    exp_ready = !RESET && !m_full[m_wb];
    exp_req   = !RESET && (m_phase == 0) && m_full[m_rb] && DRV_READY;
    chk("wr_ready", WR_READY, exp_ready);
    chk("lines_pending", LINES_PENDING, int'(m_full[0]) + int'(m_full[1]));
    chk("err_framing", ERR_FRAMING, m_err);
    chk("drv_request", DRV_REQUEST, exp_req);
    chk("line_sent", LINE_SENT, m_phase == 2);
    if (m_dout_ok) begin
      chk("data0", DATA0, m_dout[23:0]);
      chk("data1", DATA1, m_dout[47:24]);
      chk("data2", DATA2, m_dout[71:48]);
    end
    if (DRV_REQUEST === 1'b1) req_seen++;
    if (LINE_SENT === 1'b1) sent_seen++;
    acc = WR_VALID && exp_ready;
    last_acc = acc;
    if (!RESET) begin
      waddr = int'(m_wb) * LINE_LEN + m_cnt;
      raddr = int'(m_rb) * LINE_LEN + int'(RD_ADDR);
      nd    = m_mem[raddr];
      nd_ok = m_ok[raddr] && !(acc && waddr == raddr);
      close = 1'b0;
      if (acc) begin
        m_mem[waddr] = WR_DATA;
        m_ok[waddr]  = 1'b1;
        at_end = (m_cnt == LINE_LEN - 1);
        if (WR_LAST != at_end) m_err = 1'b1;
        close = WR_LAST || at_end;
      end
      if (m_phase == 2) begin
        m_full[m_rb] = 1'b0;
        m_rb = !m_rb;
        m_phase = 0;
      end else if (m_phase == 1 && DRV_TX_DONE) begin
        m_phase = 2;
      end else if (exp_req) begin
        m_phase = 1;
      end
      if (close) begin
        m_full[m_wb] = 1'b1;
        m_wb = !m_wb;
        m_cnt = 0;
      end else if (acc) begin
        m_cnt++;
      end
      m_dout = nd;
      m_dout_ok = nd_ok;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic write_line(input int n, input int last_at, input logic [7:0] salt);
    int t;
    for (int i = 0; i < n; i++) begin
      WR_VALID = 1'b1;
      WR_DATA  = pat(i, salt);
      WR_LAST  = (i == last_at);
      t = 0;
      do begin
        step();
        t++;
      end while (!last_acc && t < 200);
      if (!last_acc) begin
        chk("write_accept", last_acc, 1'b1);
        break;
      end
    end
    WR_VALID = 1'b0;
    WR_LAST  = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int r0;
    r0 = req_seen;
    for (int t = 0; t < budget && req_seen == r0; t++) step();
    chk("request_seen", req_seen - r0, 1);
  endtask

  task automatic wait_sent(input int budget);
    int s0;
    s0 = sent_seen;
    for (int t = 0; t < budget && sent_seen == s0; t++) step();
    chk("line_sent_seen", sent_seen - s0, 1);
  endtask

  // Hand one full bank to the serializer and let it finish.
  task automatic serve();
    DRV_READY = 1'b1;
    wait_req(20);
    DRV_READY = 1'b0;
    for (int t = 0; t < 6; t++) begin
      RD_ADDR    = 6'($urandom_range(0, 63));
      DRV_ACTIVE = (t > 0);
      step();
    end
    DRV_ACTIVE  = 1'b0;
    DRV_TX_DONE = 1'b1;
    step();
    DRV_TX_DONE = 1'b0;
    wait_sent(10);
  endtask

  initial begin
    int            idx;
    int            s0;
    logic [DW-1:0] p;
    logic [95:0]   r;

    model_reset();
    // Reset values
    step();
    step();
    chk("rst_wr_ready", WR_READY, 1'b0);
    chk("rst_pending", LINES_PENDING, 2'd0);
    chk("rst_request", DRV_REQUEST, 1'b0);
    RESET = 1'b0;
    step();

    // One full line, one request, read-back, release
    DRV_READY = 1'b1;
    write_line(64, 63, 8'h00);
    step(); step(); step();
    chk("t1_one_request", req_seen, 1);
    RD_ADDR = 6'd5;
    step();
    chk("t1_data0_addr5", DATA0, 24'h054585);
    chk("t1_data2_addr5", DATA2, 24'h054585);
    DRV_ACTIVE = 1'b1;
    step();
    DRV_ACTIVE  = 1'b0;
    DRV_TX_DONE = 1'b1;
    step();
    DRV_TX_DONE = 1'b0;
    chk("t1_line_sent", LINE_SENT, 1'b1);
    chk("t1_pending_1", LINES_PENDING, 2'd1);
    step();
    chk("t1_sent_done", LINE_SENT, 1'b0);
    chk("t1_pending_0", LINES_PENDING, 2'd0);

    // Back-to-back lines with the serializer held off
    DRV_READY = 1'b0;
    idx = 0;
    WR_VALID = 1'b1;
    for (int t = 0; t < 200; t++) begin
      WR_DATA = pat(idx, 8'h11);
      WR_LAST = (idx % 64 == 63);
      step();
      if (last_acc) idx++;
    end
    chk("t2_accepted_128", idx, 128);
    chk("t2_ready_low", WR_READY, 1'b0);
    chk("t2_pending_2", LINES_PENDING, 2'd2);
    DRV_READY = 1'b1;
    wait_req(10);
    DRV_READY   = 1'b0;
    DRV_TX_DONE = 1'b1;
    step();
    DRV_TX_DONE = 1'b0;
    chk("t2_ready_in_release", WR_READY, 1'b0);
    step();
    chk("t2_ready_after_release", WR_READY, 1'b1);
    for (int t = 0; t < 200 && idx < 192; t++) begin
      WR_DATA = pat(idx, 8'h11);
      WR_LAST = (idx % 64 == 63);
      step();
      if (last_acc) idx++;
    end
    WR_VALID = 1'b0;
    WR_LAST  = 1'b0;
    chk("t2_accepted_192", idx, 192);
    chk("t2_pending_2b", LINES_PENDING, 2'd2);
    serve();
    serve();
    chk("t2_drained", LINES_PENDING, 2'd0);

    // Short line
    chk("t3_err_clear", ERR_FRAMING, 1'b0);
    write_line(41, 40, 8'h22);
    chk("t3_err_short", ERR_FRAMING, 1'b1);
    chk("t3_pending_1", LINES_PENDING, 2'd1);
    write_line(64, 63, 8'h33);
    chk("t3_pending_2", LINES_PENDING, 2'd2);
    serve();
    serve();

    // Full-length line without WR_LAST
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
    chk("t4_err_reset", ERR_FRAMING, 1'b0);
    write_line(64, -1, 8'h44);
    chk("t4_err_nolast", ERR_FRAMING, 1'b1);
    chk("t4_pending_1", LINES_PENDING, 2'd1);

    // Close and release in the same cycle
    DRV_READY = 1'b1;
    wait_req(10);
    DRV_READY  = 1'b0;
    DRV_ACTIVE = 1'b1;
    step();
    DRV_ACTIVE = 1'b0;
    write_line(63, -1, 8'h55);
    chk("t5_pending_before", LINES_PENDING, 2'd1);
    DRV_TX_DONE = 1'b1;
    step();
    DRV_TX_DONE = 1'b0;
    WR_VALID = 1'b1;
    WR_DATA  = pat(63, 8'h55);
    WR_LAST  = 1'b1;
    s0 = sent_seen;
    step();
    WR_VALID = 1'b0;
    WR_LAST  = 1'b0;
    chk("t5_close_accepted", last_acc, 1'b1);
    chk("t5_sent_same_cycle", sent_seen - s0, 1);
    chk("t5_pending_after", LINES_PENDING, 2'd1);
    chk("t5_ready_after", WR_READY, 1'b1);

    // Reset while a line is out and 20 words are buffered
    DRV_READY = 1'b1;
    wait_req(10);
    DRV_READY  = 1'b0;
    DRV_ACTIVE = 1'b1;
    step();
    DRV_ACTIVE = 1'b0;
    write_line(20, -1, 8'h66);
    chk("t6_pending_pre", LINES_PENDING, 2'd1);
    RESET = 1'b1;
    step();
    chk("t6_rst_ready", WR_READY, 1'b0);
    chk("t6_rst_request", DRV_REQUEST, 1'b0);
    chk("t6_rst_sent", LINE_SENT, 1'b0);
    chk("t6_rst_pending", LINES_PENDING, 2'd0);
    chk("t6_rst_err", ERR_FRAMING, 1'b0);
    chk("t6_rst_data", {DATA2, DATA1, DATA0}, 72'd0);
    RESET = 1'b0;
    step();
    write_line(64, 63, 8'hAA);
    DRV_READY = 1'b1;
    wait_req(10);
    DRV_READY = 1'b0;
    RD_ADDR = 6'd7;
    step();
    p = pat(7, 8'hAA);
    chk("t6_bank0_addr7", DATA0, p[23:0]);
    DRV_TX_DONE = 1'b1;
    step();
    DRV_TX_DONE = 1'b0;
    wait_sent(10);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      r = {$urandom(), $urandom(), $urandom()};
      WR_VALID    = ($urandom_range(0, 3) != 0);
      WR_DATA     = r[DW-1:0];
      WR_LAST     = ($urandom_range(0, 40) == 0);
      DRV_READY   = ($urandom_range(0, 3) != 0);
      DRV_ACTIVE  = ($urandom_range(0, 1) == 1);
      DRV_TX_DONE = ($urandom_range(0, 15) == 0);
      RD_ADDR     = 6'($urandom_range(0, 63));
      RESET       = ($urandom_range(0, 999) == 0);
      step();
    end
    RESET = 1'b0;
    WR_VALID = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mbi5153_line_buf.md
Name: mbi5153_line_buf

Overview:
- Ping-pong line buffer directly upstream of the MBI5153 serializer (mbi5153_data).
- Accepts one scan line of RGB pixels per line from the frame-memory reader over a valid/ready stream and stores it in one of two banks.
- Serves the serializer's ADDR with DATA0..2 at a fixed 1-cycle latency from the other bank.
- Issues the serializer's REQUEST and frees the bank on its TX_DONE, so line N+1 fills while line N shifts out.

Parameters:
- NUM_IC_CHAIN, 4: ICs per chain.
- NUM_CH_IC, 16: channels per IC.
- NUMBER_OF_LANES, 3: RGB lanes, 1..3.
- LINE_LEN, NUM_IC_CHAIN*NUM_CH_IC: words per line (64).
- ADDR_WIDTH, $clog2(LINE_LEN): address width (6).

Ports:
- CLK  in  1  system clock; also the serializer clock.
- RESET  in  1  asynchronous, active-high.
- WR_VALID  in  1  write word valid.
- WR_READY  out  1  buffer can accept a word.
- WR_DATA  in  24*NUMBER_OF_LANES  lane k in bits [24k+23:24k], {R,G,B} 8 bits each.
- WR_LAST  in  1  marks the final word of a line.
- DRV_READY  in  1  serializer READY.
- DRV_ACTIVE  in  1  serializer ACTIVE.
- DRV_TX_DONE  in  1  serializer TX_DONE strobe.
- DRV_REQUEST  out  1  one-cycle request to send a line.
- RD_ADDR  in  ADDR_WIDTH  serializer ADDR.
- DATA0, DATA1, DATA2  out  24 each  lane read data; lanes >= NUMBER_OF_LANES are held 0.
- LINE_SENT  out  1  one-cycle pulse when a bank is released.
- LINES_PENDING  out  2  number of full banks (0..2).
- ERR_FRAMING  out  1  sticky framing error.

Behaviour:
- Reset (asynchronous) values: full[1:0]=0, wb=0, rb=0, wr_cnt=0, FSM=IDLE, DRV_REQUEST=0, LINE_SENT=0, DATA0..2=0, ERR_FRAMING=0. WR_READY=0 while RESET is asserted.
- Storage:
  - Simple dual-port RAM, depth 2*LINE_LEN, width 24*NUMBER_OF_LANES.
  - Write address {wb, wr_cnt}; read address {rb, RD_ADDR}.
- Write side:
  - WR_READY = ~full[wb] & ~RESET.
  - A word is accepted when WR_VALID & WR_READY; it is written at {wb, wr_cnt} and wr_cnt increments.
  - A line closes on an accepted word with WR_LAST=1 or wr_cnt==LINE_LEN-1. On close: full[wb]<=1, wb toggles, wr_cnt<=0.
  - ERR_FRAMING sets if WR_LAST arrives with wr_cnt!=LINE_LEN-1 (short line; remaining addresses keep stale data).
  - ERR_FRAMING also sets if wr_cnt==LINE_LEN-1 is accepted without WR_LAST.
  - ERR_FRAMING clears only on RESET.
- Read side:
  - DATAk <= RAM[{rb, RD_ADDR}] lane k, registered, latency exactly 1 CLK, updated every cycle regardless of FSM state.
- Read FSM:
  - IDLE: if full[rb] & DRV_READY, assert DRV_REQUEST for exactly 1 cycle and go to WAIT_ACT.
  - WAIT_ACT: wait for DRV_ACTIVE=1, then go to WAIT_DONE. A DRV_TX_DONE seen here is also honoured and goes straight to RELEASE.
  - WAIT_DONE: on DRV_TX_DONE go to RELEASE.
  - RELEASE: full[rb]<=0, rb toggles, LINE_SENT=1 for 1 cycle, return to IDLE.
  - DRV_REQUEST never re-asserts before RELEASE.
- Simultaneous events:
  - A write-side close and a read-side release in the same cycle act on different banks; both take effect.
  - LINES_PENDING = full[0]+full[1], updated the same cycle.
  - When both banks are full, WR_READY=0 until RELEASE.
- RESET mid-line discards all buffered data, and the FSM returns to IDLE.

Decomposition:
- Package mbi5153_pkg holds:
  - LINE_LEN and ADDR_WIDTH derivation;
  - read-FSM state encoding (IDLE=0, WAIT_ACT=1, WAIT_DONE=2, RELEASE=3);
  - lane slice width constant (24).
- One sub-module, mbi5153_line_ram: simple dual-port, synchronous-read, no reset on the array.
- The control logic stays in mbi5153_line_buf.

Test Plan:
- Write 64 words (word i = {8'hi, 8'h40+i, 8'h80+i} per lane), WR_LAST on i=63, with DRV_READY=1 -> DRV_REQUEST pulses once. Driving RD_ADDR=5 gives DATA0=24'h05_45_85 one cycle later. Then emulate ACTIVE/TX_DONE -> LINE_SENT pulses and LINES_PENDING goes 1->0.
- Hold DRV_READY=0 and stream 3 lines back-to-back -> WR_READY drops after 128 accepted words and LINES_PENDING=2. Raising DRV_READY and completing one TX_DONE frees one bank; WR_READY returns the cycle after RELEASE.
- WR_LAST on word 40 -> ERR_FRAMING=1, bank marked full, the next line starts at wr_cnt=0 in the other bank.
- Word 63 without WR_LAST -> line closes, ERR_FRAMING=1.
- Line close and DRV_TX_DONE release in the same cycle -> both banks are updated correctly and LINES_PENDING is unchanged.
- Assert RESET during the WAIT_DONE state with 20 words buffered -> all outputs return to their reset values, and the first post-reset line lands in bank 0.
